commit_unit_l1: RTL and testbench

In-order commit unit that produces the `CommitNotif` stream consumed by the sequence number generator (for reclaim) and by architectural state. Completed instructions arrive out of order from writeback, each tagged with the sequence number issued at fetch. They are buffered in a table indexed by that sequence number. Each is retired in allocation order, one per cycle, as a `CommitNotif` publication.

---
 rtl/commit_unit_l1.sv | 96 +++++++++
 tb/tb_commit_unit_l1.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit_l1.sv
// In-order commit unit: buffers out-of-order completions by sequence number and
// retires them in order, one per cycle. Optional macro: COMMIT_UNIT_BYPASS_EN.
module commit_unit_l1 #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      complete_val,
  output logic                      complete_rdy,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  output logic [31:0]               commit_pc,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen,
  output logic                      commit_val,
  output logic                      err
);

  localparam int unsigned DEPTH = 2 ** p_seq_num_bits;

  logic [DEPTH-1:0]          valid;
  logic [31:0]               pc_q    [DEPTH];
  logic [4:0]                waddr_q [DEPTH];
  logic [31:0]               wdata_q [DEPTH];
  logic                      wen_q   [DEPTH];
  logic [p_seq_num_bits-1:0] head;

  logic accept;
  logic bypass;
  logic write;
  logic commit_fire;

  assign complete_rdy = rst;

  always_comb begin
    accept = complete_val & complete_rdy;
    bypass = 1'b0;
`ifdef COMMIT_UNIT_BYPASS_EN
    bypass = accept && (complete_seq_num == head) && !valid[head];
`endif
    write       = accept & ~bypass;
    commit_fire = valid[head] | bypass;
  end

  // Payload is zeroed whenever nothing commits, which also covers reset.
  always_comb begin
    commit_val     = commit_fire;
    commit_seq_num = head;
    commit_pc      = '0;
    commit_waddr   = '0;
    commit_wdata   = '0;
    commit_wen     = 1'b0;
    if (bypass) begin
      commit_pc    = complete_pc;
      commit_waddr = complete_waddr;
      commit_wdata = complete_wdata;
      commit_wen   = complete_wen;
    end else if (valid[head]) begin
      commit_pc    = pc_q[head];
      commit_waddr = waddr_q[head];
      commit_wdata = wdata_q[head];
      commit_wen   = wen_q[head];
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      pc_q[complete_seq_num]    <= complete_pc;
      waddr_q[complete_seq_num] <= complete_waddr;
      wdata_q[complete_seq_num] <= complete_wdata;
      wen_q[complete_seq_num]   <= complete_wen;
    end
  end

  // A duplicate landing on head in its commit cycle is consumed by that commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      head  <= '0;
      err   <= 1'b0;
    end else begin
      if (write) begin
        valid[complete_seq_num] <= 1'b1;
        if (valid[complete_seq_num]) err <= 1'b1;
      end
      if (valid[head]) valid[head] <= 1'b0;
      if (commit_fire) head <= head + 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_unit_l1.sv
// Directed testbench for commit_unit_l1; bypass scenario runs when
// COMMIT_UNIT_BYPASS_EN is defined, the default scenarios otherwise.
module tb_commit_unit_l1;

  logic        clk = 1'b0;
  logic        rst;
  logic        complete_val;
  logic        complete_rdy;
  logic [4:0]  complete_seq_num;
  logic [31:0] complete_pc;
  logic [4:0]  complete_waddr;
  logic [31:0] complete_wdata;
  logic        complete_wen;
  logic [31:0] commit_pc;
  logic [4:0]  commit_seq_num;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_wdata;
  logic        commit_wen;
  logic        commit_val;
  logic        err;

  int checks   = 0;
  int failures = 0;

  commit_unit_l1 #(.p_seq_num_bits(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .complete_val     (complete_val),
    .complete_rdy     (complete_rdy),
    .complete_seq_num (complete_seq_num),
    .complete_pc      (complete_pc),
    .complete_waddr   (complete_waddr),
    .complete_wdata   (complete_wdata),
    .complete_wen     (complete_wen),
    .commit_pc        (commit_pc),
    .commit_seq_num   (commit_seq_num),
    .commit_waddr     (commit_waddr),
    .commit_wdata     (commit_wdata),
    .commit_wen       (commit_wen),
    .commit_val       (commit_val),
    .err              (err)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] ce(input logic v, input logic [4:0] s,
                                     input logic [31:0] pc, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic we);
    return {v, s, pc, wa, wd, we};
  endfunction

  function automatic logic [75:0] cobs();
    return {commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen};
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [31:0] pc,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    complete_val     = v;
    complete_seq_num = s;
    complete_pc      = pc;
    complete_waddr   = wa;
    complete_wdata   = wd;
    complete_wen     = we;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    chk("reset_commit", cobs(), ce(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0));
    chk("reset_rdy", 76'(complete_rdy), 76'(1'b0));
    chk("reset_err", 76'(err), 76'(1'b0));
    rst = 1'b1;
    #1;
    chk("rdy_after_release", 76'(complete_rdy), 76'(1'b1));

`ifdef COMMIT_UNIT_BYPASS_EN
    for (int unsigned i = 0; i < 4; i++) tick();
    drive(1'b1, 5'd0, 32'h100, 5'd1, 32'hA0, 1'b1);
    #1;
    chk("byp_same_cycle", cobs(), ce(1'b1, 5'd0, 32'h100, 5'd1, 32'hA0, 1'b1));
    tick();
    idle();
    chk("byp_head_next", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));
    drive(1'b1, 5'd2, 32'h108, 5'd3, 32'hA2, 1'b0);
    #1;
    chk("byp_nonhead_nocommit", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));
    tick();
    drive(1'b1, 5'd1, 32'h104, 5'd2, 32'hA1, 1'b1);
    #1;
    chk("byp_seq1", cobs(), ce(1'b1, 5'd1, 32'h104, 5'd2, 32'hA1, 1'b1));
    tick();
    idle();
    chk("byp_seq2_table", cobs(), ce(1'b1, 5'd2, 32'h108, 5'd3, 32'hA2, 1'b0));
    tick();
    chk("byp_empty", cobs(), ce(1'b0, 5'd3, 32'h0, 5'd0, 32'h0, 1'b0));
    chk("byp_err", 76'(err), 76'(1'b0));
`else
    // In-order completion
    drive(1'b1, 5'd0, 32'h100, 5'd1, 32'hA0, 1'b1);
    #1;
    chk("no_bypass_path", cobs(), ce(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0));
    tick();
    chk("inord_seq0", cobs(), ce(1'b1, 5'd0, 32'h100, 5'd1, 32'hA0, 1'b1));
    drive(1'b1, 5'd1, 32'h104, 5'd2, 32'hA1, 1'b1);
    tick();
    chk("inord_seq1", cobs(), ce(1'b1, 5'd1, 32'h104, 5'd2, 32'hA1, 1'b1));
    drive(1'b1, 5'd2, 32'h108, 5'd3, 32'hA2, 1'b0);
    tick();
    chk("inord_seq2", cobs(), ce(1'b1, 5'd2, 32'h108, 5'd3, 32'hA2, 1'b0));
    idle();
    tick();
    chk("inord_empty", cobs(), ce(1'b0, 5'd3, 32'h0, 5'd0, 32'h0, 1'b0));

    // Out-of-order completion: 5, 4, then head 3
    drive(1'b1, 5'd5, 32'h114, 5'd6, 32'hB5, 1'b1);
    tick();
    chk("ooo_wait5", cobs(), ce(1'b0, 5'd3, 32'h0, 5'd0, 32'h0, 1'b0));
    drive(1'b1, 5'd4, 32'h110, 5'd5, 32'hB4, 1'b0);
    tick();
    chk("ooo_wait4", cobs(), ce(1'b0, 5'd3, 32'h0, 5'd0, 32'h0, 1'b0));
    drive(1'b1, 5'd3, 32'h10C, 5'd4, 32'hB3, 1'b1);
    tick();
    idle();
    chk("ooo_seq3", cobs(), ce(1'b1, 5'd3, 32'h10C, 5'd4, 32'hB3, 1'b1));
    tick();
    chk("ooo_seq4", cobs(), ce(1'b1, 5'd4, 32'h110, 5'd5, 32'hB4, 1'b0));
    tick();
    chk("ooo_seq5", cobs(), ce(1'b1, 5'd5, 32'h114, 5'd6, 32'hB5, 1'b1));
    tick();
    chk("ooo_empty", cobs(), ce(1'b0, 5'd6, 32'h0, 5'd0, 32'h0, 1'b0));

    // Wrap-around: complete and commit 6..31, then seq 0 again
    for (int unsigned i = 6; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h200 + 32'(4 * i), 5'(i), 32'(3 * i), 1'b1);
      tick();
      chk("wrap_seq", cobs(), ce(1'b1, 5'(i), 32'h200 + 32'(4 * i), 5'(i), 32'(3 * i), 1'b1));
    end
    idle();
    tick();
    chk("wrap_head0", cobs(), ce(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0));
    drive(1'b1, 5'd0, 32'h300, 5'd7, 32'h55, 1'b1);
    tick();
    idle();
    chk("wrap_seq0_again", cobs(), ce(1'b1, 5'd0, 32'h300, 5'd7, 32'h55, 1'b1));
    tick();
    chk("wrap_empty", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));

    // Duplicate completion of seq 3 while head (1) is pending
    drive(1'b1, 5'd3, 32'hAAA0, 5'd9, 32'h1111, 1'b0);
    tick();
    chk("dup_first_err", 76'(err), 76'(1'b0));
    drive(1'b1, 5'd3, 32'hBBB0, 5'd10, 32'h2222, 1'b1);
    tick();
    idle();
    chk("dup_err_set", 76'(err), 76'(1'b1));
    chk("dup_no_commit", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));
    drive(1'b1, 5'd1, 32'h404, 5'd11, 32'h3333, 1'b1);
    tick();
    chk("dup_seq1", cobs(), ce(1'b1, 5'd1, 32'h404, 5'd11, 32'h3333, 1'b1));
    drive(1'b1, 5'd2, 32'h408, 5'd12, 32'h4444, 1'b0);
    tick();
    idle();
    chk("dup_seq2", cobs(), ce(1'b1, 5'd2, 32'h408, 5'd12, 32'h4444, 1'b0));
    tick();
    chk("dup_seq3_second", cobs(), ce(1'b1, 5'd3, 32'hBBB0, 5'd10, 32'h2222, 1'b1));
    tick();
    chk("dup_err_sticky", 76'(err), 76'(1'b1));
    chk("dup_empty", cobs(), ce(1'b0, 5'd4, 32'h0, 5'd0, 32'h0, 1'b0));

    // Reset mid-operation with seq 5..7 pending
    for (int unsigned i = 5; i < 8; i++) begin
      drive(1'b1, 5'(i), 32'h500 + 32'(i), 5'(i), 32'(i), 1'b1);
      tick();
    end
    idle();
    chk("pre_reset_wait", cobs(), ce(1'b0, 5'd4, 32'h0, 5'd0, 32'h0, 1'b0));
    rst = 1'b0;
    #1;
    chk("midrst_commit", cobs(), ce(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0));
    chk("midrst_rdy", 76'(complete_rdy), 76'(1'b0));
    chk("midrst_err", 76'(err), 76'(1'b0));
    tick();
    tick();
    chk("midrst_hold", cobs(), ce(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0));
    rst = 1'b1;
    drive(1'b1, 5'd0, 32'h600, 5'd13, 32'h6666, 1'b1);
    tick();
    idle();
    chk("postrst_seq0", cobs(), ce(1'b1, 5'd0, 32'h600, 5'd13, 32'h6666, 1'b1));
    tick();
    chk("postrst_only0", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));
    tick();
    chk("postrst_still_empty", cobs(), ce(1'b0, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
